// File: rtl/buffer_stream_reader.sv
// rtl/buffer_stream_reader.sv - streams a buffer region out through a 4-entry FIFO with credit-limited reads
// Optional BUF_READER_STRIDE_EN adds a stride input that sets the address step.
module buffer_stream_reader #(
    parameter int DataWidth = 8,
    parameter int BuffDepth = 256,
    parameter int AddrWidth = $clog2(BuffDepth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AddrWidth-1:0] base_addr,
    input  logic [AddrWidth:0]   length,
`ifdef BUF_READER_STRIDE_EN
    input  logic [AddrWidth-1:0] stride,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 buf_read_en,
    output logic [AddrWidth-1:0] buf_addr,
    input  logic [DataWidth-1:0] buf_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DataWidth-1:0] m_data
);

    localparam logic [AddrWidth:0] DEPTH = (AddrWidth+1)'(BuffDepth);
    localparam int                 FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [AddrWidth-1:0]   r_addr;
    logic [AddrWidth:0]     r_reads_left;
    logic [AddrWidth:0]     r_beats_left;
    logic                   r_inflight;
    logic                   r_zero_done;

    logic [DataWidth-1:0]   r_mem [FIFO_DEPTH];
    logic [1:0]             r_wr_ptr;
    logic [1:0]             r_rd_ptr;
    logic [2:0]             r_count;

    logic                   w_accept;
    logic                   w_accept_xfer;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last_read;
    logic                   w_last_beat;
    logic [2:0]             w_occupancy;
    logic [AddrWidth-1:0]   w_step;
    logic [AddrWidth:0]     w_addr_sum;
    logic [AddrWidth-1:0]   w_next_addr;

`ifdef BUF_READER_STRIDE_EN
    logic [AddrWidth-1:0]   r_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= '0;
        end else if (w_accept_xfer) begin
            r_step <= stride;
        end
    end

    assign w_step = r_step;
`else
    assign w_step = AddrWidth'(1);
`endif

    assign w_accept      = (r_state == S_IDLE) && start;
    assign w_accept_xfer = w_accept && (length != '0);

    // Reads and FIFO entries together never exceed the FIFO depth, so the
    // registered read data always has a free slot when it lands.
    assign w_occupancy = r_count + {2'b00, r_inflight};
    assign w_issue     = (r_state == S_RUN) && (r_reads_left != '0) && (w_occupancy < 3'd4);
    assign w_push      = r_inflight;
    assign w_pop       = (r_count != 3'd0) && m_ready;
    assign w_last_read = w_issue && (r_reads_left == (AddrWidth+1)'(1));
    assign w_last_beat = (r_state == S_DRAIN) && w_pop && (r_beats_left == (AddrWidth+1)'(1));

    // Works for non power-of-two depths as long as addresses and step stay below BuffDepth.
    assign w_addr_sum  = {1'b0, r_addr} + {1'b0, w_step};
    assign w_next_addr = (w_addr_sum >= DEPTH) ? AddrWidth'(w_addr_sum - DEPTH)
                                               : AddrWidth'(w_addr_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_xfer) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_read) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_beat) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        buf_read_en = w_issue;
        done        = r_zero_done || w_last_beat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_reads_left <= '0;
            r_beats_left <= '0;
            r_inflight   <= 1'b0;
            r_zero_done  <= 1'b0;
        end else begin
            r_zero_done <= w_accept && (length == '0);
            r_inflight  <= w_issue;
            if (w_accept_xfer) begin
                r_addr       <= base_addr;
                r_reads_left <= length;
                r_beats_left <= length;
            end else begin
                if (w_issue) begin
                    r_addr       <= w_next_addr;
                    r_reads_left <= r_reads_left - 1'b1;
                end
                if (w_pop) begin
                    r_beats_left <= r_beats_left - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= buf_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign buf_addr = r_addr;
    assign m_valid  = (r_count != 3'd0);
    assign m_data   = r_mem[r_rd_ptr];

endmodule
